pbvi_solver_param: RTL and testbench

Parametrised point-based value-iteration (PBVI) solver for discrete POMDPs, sized by state, action, observation and belief-point count and by data width. It is the next-generation `solve_pbvi`. New relative to that block:
- explicit belief-point input;
- start/busy/done handshake;
- early termination on an epsilon convergence test;
- iteration-count reporting.

It sits under the policy controller, which loads a model and reads back one alpha vector and best action per belief point.

---
 rtl/pbvi_solver_param.sv | 258 +++++++++++++++++++++++++
 tb/tb_pbvi_solver_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pbvi_solver_param.sv
// Point-based value-iteration solver for a small discrete POMDP.
// Runs full PBVI backups over N_PT belief points until the largest alpha
// change drops to eps or max_iter iterations have completed.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   max_iter, eps       iteration limit and convergence threshold
//   discount            gamma, Q0.W
//   belief, alpha_in    belief points (Q0.W) and initial alpha vectors
//   vec_reward          r(a,s)
//   trans, observe      T(a,s,s') and O(a,s',o), Q0.W
//   busy, done          run in progress / one-cycle completion pulse
//   converged           last run stopped on the eps test
//   iter_count          iterations completed in the last run
//   point_action        best action per belief point
//   alpha_out           resulting alpha vectors
//
// Handshake: start is sampled only while idle; busy rises the cycle after,
// and done pulses for one cycle (with busy dropping) when results land on
// the held outputs. A start seen while busy is ignored.
module pbvi_solver_param #(
  parameter int N_S  = 2,
  parameter int N_A  = 3,
  parameter int N_O  = 2,
  parameter int N_PT = 16,
  parameter int W    = 16,
  localparam int AW  = (N_A > 1) ? $clog2(N_A) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [15:0]                             max_iter,
  input  logic [W-1:0]                            eps,
  input  logic [W-1:0]                            discount,
  input  logic [N_PT-1:0][N_S-1:0][W-1:0]         belief,
  input  logic [N_PT-1:0][N_S-1:0][W-1:0]         alpha_in,
  input  logic [N_A-1:0][N_S-1:0][W-1:0]          vec_reward,
  input  logic [N_A-1:0][N_S-1:0][N_S-1:0][W-1:0] trans,
  input  logic [N_A-1:0][N_S-1:0][N_O-1:0][W-1:0] observe,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    converged,
  output logic [15:0]                             iter_count,
  output logic [N_PT-1:0][AW-1:0]                 point_action,
  output logic [N_PT-1:0][N_S-1:0][W-1:0]         alpha_out
);
  localparam int SW = (N_S > 1) ? $clog2(N_S) : 1;
  localparam int OW = (N_O > 1) ? $clog2(N_O) : 1;
  localparam int PW = (N_PT > 1) ? $clog2(N_PT) : 1;
  localparam int DW = 2 * W + $clog2(N_S);
  localparam logic [SW-1:0] S_LAST = SW'(N_S - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_O - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N_A - 1);
  localparam logic [PW-1:0] P_LAST = PW'(N_PT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, G_MAC, G_DOT, G_CMP, O_ACC, A_VAL, A_CMP, COMMIT, DONE
  } state_t;
  state_t state;

  // Model snapshot taken in LOAD so inputs may change during a run.
  logic [N_PT-1:0][N_S-1:0][W-1:0]         b_r, gam, new_a;
  logic [N_A-1:0][N_S-1:0][W-1:0]          r_r;
  logic [N_A-1:0][N_S-1:0][N_S-1:0][W-1:0] t_r;
  logic [N_A-1:0][N_S-1:0][N_O-1:0][W-1:0] o_r;
  logic [W-1:0]                            disc_r, eps_r, delta;
  logic [15:0]                             max_r, iter_n;
  logic [N_PT-1:0][AW-1:0]                 new_act;

  logic [N_S-1:0][W-1:0] g_vec, gstar, acc, alpha_a;
  logic [DW-1:0]         d_acc, best_d, v_acc, best_v;
  logic [PW-1:0]         p_cnt, k_cnt;
  logic [AW-1:0]         a_cnt;
  logic [OW-1:0]         o_cnt;
  logic [SW-1:0]         s_cnt, sp_cnt;
  logic                  aval_dot, commit_swap;

  logic [W-1:0]  mac_term, diff;
  logic [DW-1:0] dot_term, val_term;

  function automatic logic [W-1:0] mulq(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] pr;
    pr = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(pr >> W);
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  always_comb begin
    mac_term = mulq(mulq(t_r[a_cnt][s_cnt][sp_cnt], o_r[a_cnt][sp_cnt][o_cnt]),
                    gam[k_cnt][sp_cnt]);
    dot_term = {{(DW-W){1'b0}}, b_r[p_cnt][s_cnt]} * {{(DW-W){1'b0}}, g_vec[s_cnt]};
    val_term = {{(DW-W){1'b0}}, b_r[p_cnt][s_cnt]} * {{(DW-W){1'b0}}, alpha_a[s_cnt]};
    diff = (new_a[p_cnt][s_cnt] >= gam[p_cnt][s_cnt]) ?
           new_a[p_cnt][s_cnt] - gam[p_cnt][s_cnt] :
           gam[p_cnt][s_cnt] - new_a[p_cnt][s_cnt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;  busy <= 1'b0;  done <= 1'b0;  converged <= 1'b0;
      iter_count <= '0;  point_action <= '0;  alpha_out <= '0;
      b_r <= '0;  gam <= '0;  new_a <= '0;  r_r <= '0;  t_r <= '0;  o_r <= '0;
      disc_r <= '0;  eps_r <= '0;  delta <= '0;  max_r <= '0;  iter_n <= '0;
      new_act <= '0;  g_vec <= '0;  gstar <= '0;  acc <= '0;  alpha_a <= '0;
      d_acc <= '0;  best_d <= '0;  v_acc <= '0;  best_v <= '0;
      p_cnt <= '0;  k_cnt <= '0;  a_cnt <= '0;  o_cnt <= '0;  s_cnt <= '0;  sp_cnt <= '0;
      aval_dot <= 1'b0;  commit_swap <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          b_r <= belief;  gam <= alpha_in;  r_r <= vec_reward;  t_r <= trans;
          o_r <= observe;  disc_r <= discount;  eps_r <= eps;  max_r <= max_iter;
          iter_n <= '0;  p_cnt <= '0;  k_cnt <= '0;  a_cnt <= '0;  o_cnt <= '0;
          s_cnt <= '0;  sp_cnt <= '0;  aval_dot <= 1'b0;  commit_swap <= 1'b0;
          if (max_iter == 16'd0) begin
            // Nothing to iterate: hand the initial vectors straight back.
            alpha_out <= alpha_in;  point_action <= '0;  iter_count <= '0;
            converged <= 1'b0;  done <= 1'b1;  busy <= 1'b0;  state <= DONE;
          end else begin
            state <= G_MAC;
          end
        end
        G_MAC: begin
          // s is the outer index, s' the inner; g(s) restarts when s'=0.
          g_vec[s_cnt] <= sat_add((sp_cnt == '0) ? {W{1'b0}} : g_vec[s_cnt], mac_term);
          if (sp_cnt == S_LAST) begin
            sp_cnt <= '0;
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              state <= G_DOT;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end else begin
            sp_cnt <= sp_cnt + SW'(1);
          end
        end
        G_DOT: begin
          d_acc <= ((s_cnt == '0) ? {DW{1'b0}} : d_acc) + dot_term;
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            state <= G_CMP;
          end else begin
            s_cnt <= s_cnt + SW'(1);
          end
        end
        G_CMP: begin
          // Candidate 0 always seeds the search, so ties settle on the lowest k.
          if (k_cnt == '0 || d_acc > best_d) begin
            best_d <= d_acc;
            gstar  <= g_vec;
          end
          if (k_cnt == P_LAST) begin
            k_cnt <= '0;
            state <= O_ACC;
          end else begin
            k_cnt <= k_cnt + PW'(1);
            state <= G_MAC;
          end
        end
        O_ACC: begin
          for (int s = 0; s < N_S; s++)
            acc[s] <= sat_add((o_cnt == '0) ? {W{1'b0}} : acc[s], gstar[s]);
          if (o_cnt == O_LAST) begin
            o_cnt    <= '0;
            aval_dot <= 1'b0;
            state    <= A_VAL;
          end else begin
            o_cnt <= o_cnt + OW'(1);
            state <= G_MAC;
          end
        end
        A_VAL: begin
          if (!aval_dot) begin
            for (int s = 0; s < N_S; s++)
              alpha_a[s] <= sat_add(r_r[a_cnt][s], mulq(disc_r, acc[s]));
            aval_dot <= 1'b1;
            s_cnt    <= '0;
          end else begin
            v_acc <= ((s_cnt == '0) ? {DW{1'b0}} : v_acc) + val_term;
            if (s_cnt == S_LAST) begin
              s_cnt    <= '0;
              aval_dot <= 1'b0;
              state    <= A_CMP;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        A_CMP: begin
          if (a_cnt == '0 || v_acc > best_v) begin
            best_v         <= v_acc;
            new_a[p_cnt]   <= alpha_a;
            new_act[p_cnt] <= a_cnt;
          end
          state <= G_MAC;
          if (a_cnt == A_LAST) begin
            a_cnt <= '0;
            if (p_cnt == P_LAST) begin
              p_cnt       <= '0;
              commit_swap <= 1'b0;
              state       <= COMMIT;
            end else begin
              p_cnt <= p_cnt + PW'(1);
            end
          end else begin
            a_cnt <= a_cnt + AW'(1);
          end
        end
        COMMIT: begin
          if (!commit_swap) begin
            // Walk every (point, state) element to find the largest change.
            delta <= (p_cnt == '0 && s_cnt == '0) ? diff : ((diff > delta) ? diff : delta);
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              if (p_cnt == P_LAST) begin
                p_cnt       <= '0;
                commit_swap <= 1'b1;
              end else begin
                p_cnt <= p_cnt + PW'(1);
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end else begin
            gam         <= new_a;
            iter_n      <= iter_n + 16'd1;
            commit_swap <= 1'b0;
            if (delta <= eps_r || iter_n + 16'd1 == max_r) begin
              alpha_out    <= new_a;
              point_action <= new_act;
              iter_count   <= iter_n + 16'd1;
              converged    <= (delta <= eps_r);
              done         <= 1'b1;
              busy         <= 1'b0;
              state        <= DONE;
            end else begin
              state <= G_MAC;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pbvi_solver_param.sv
// Directed bench for pbvi_solver_param: reset values, zero-iteration run,
// trivial-model convergence, iteration limit, start-while-busy, mid-run
// reset and saturation. Expected results are pushed into a scoreboard queue
// when a run is launched and popped against the held outputs after done.
module tb_pbvi_solver_param;
  localparam int N_S = 2, N_A = 3, N_O = 2, N_PT = 16, W = 16, AW = 2;
  localparam int T_ITER = N_PT*N_A*(N_O*(N_PT*(N_S*N_S+N_S+1)+1)+N_S+2) + N_PT*N_S + 1;

  logic                                    clk = 1'b0;
  logic                                    rst = 1'b1;
  logic                                    start = 1'b0;
  logic [15:0]                             max_iter = '0;
  logic [W-1:0]                            eps = '0, discount = '0;
  logic [N_PT-1:0][N_S-1:0][W-1:0]         belief = '0, alpha_in = '0;
  logic [N_A-1:0][N_S-1:0][W-1:0]          vec_reward = '0;
  logic [N_A-1:0][N_S-1:0][N_S-1:0][W-1:0] trans = '0;
  logic [N_A-1:0][N_S-1:0][N_O-1:0][W-1:0] observe = '0;
  logic                                    busy, done, converged;
  logic [15:0]                             iter_count;
  logic [N_PT-1:0][AW-1:0]                 point_action;
  logic [N_PT-1:0][N_S-1:0][W-1:0]         alpha_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  pbvi_solver_param dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter), .eps(eps),
    .discount(discount), .belief(belief), .alpha_in(alpha_in),
    .vec_reward(vec_reward), .trans(trans), .observe(observe),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .point_action(point_action), .alpha_out(alpha_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Pops in the same order the push tasks used: iter_count, converged,
  // then per point the action and both alpha entries.
  task automatic check_results(input string name);
    logic [W-1:0] e;
    string t;
    e = exp_q.pop_front(); t = tag_q.pop_front();
    check({name, " ", t}, 32'(iter_count), 32'(e));
    e = exp_q.pop_front(); t = tag_q.pop_front();
    check({name, " ", t}, 32'(converged), 32'(e));
    for (int p = 0; p < N_PT; p++) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      check({name, " ", t}, 32'(point_action[p]), 32'(e));
      for (int s = 0; s < N_S; s++) begin
        e = exp_q.pop_front(); t = tag_q.pop_front();
        check({name, " ", t}, 32'(alpha_out[p][s]), 32'(e));
      end
    end
    check({name, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // With trans and observe zero every g is zero, so alpha_a = r(a) and the
  // best action is the strict-greater argmax of b.r(a) (lowest a on ties).
  task automatic push_reward_model(input logic [15:0] it, input logic cv);
    logic [63:0] v, best_v;
    int best_a;
    push_exp("iter_count", it);
    push_exp("converged", W'(cv));
    for (int p = 0; p < N_PT; p++) begin
      best_a = 0; best_v = '0;
      for (int a = 0; a < N_A; a++) begin
        v = 64'(belief[p][0]) * 64'(vec_reward[a][0]) + 64'(belief[p][1]) * 64'(vec_reward[a][1]);
        if (a == 0 || v > best_v) begin best_v = v; best_a = a; end
      end
      push_exp($sformatf("action[%0d]", p), W'(best_a));
      for (int s = 0; s < N_S; s++)
        push_exp($sformatf("alpha[%0d][%0d]", p, s), vec_reward[best_a][s]);
    end
  endtask

  task automatic push_constant(input logic [15:0] it, input logic cv, input logic [W-1:0] av);
    push_exp("iter_count", it);
    push_exp("converged", W'(cv));
    for (int p = 0; p < N_PT; p++) begin
      push_exp($sformatf("action[%0d]", p), '0);
      for (int s = 0; s < N_S; s++)
        push_exp($sformatf("alpha[%0d][%0d]", p, s), av);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_beliefs();
    for (int p = 0; p < N_PT; p++) begin
      if (p % 2 == 0) begin belief[p][0] = 16'hffff; belief[p][1] = 16'h0000; end
      else            begin belief[p][0] = 16'h8000; belief[p][1] = 16'h8000; end
    end
  endtask

  task automatic set_trivial(input logic [15:0] mi);
    trans = '0; observe = '0; alpha_in = '0;
    vec_reward[0][0] = 16'd7209; vec_reward[0][1] = 16'd0;
    vec_reward[1][0] = 16'd0;    vec_reward[1][1] = 16'd7209;
    vec_reward[2][0] = 16'd6488; vec_reward[2][1] = 16'd6488;
    discount = 16'hc000; eps = '0; max_iter = mi;
    set_beliefs();
  endtask

  // Start is sampled at edge k; done is expected to be visible to edge
  // k+2+n*T_ITER. Optionally re-pulses start pulse_at cycles into the run.
  task automatic run(input string name, input int n_iter, input int pulse_at);
    int cyc, budget;
    logic got;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    check({name, " busy after start"}, 32'(busy), 32'd1);
    budget = 2 + n_iter * T_ITER + 50;
    cyc = 0; got = 1'b0;
    while (!got && cyc < budget) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
      else if (cyc == pulse_at) start = 1'b1;
    end
    check({name, " done seen"}, 32'(got), 32'd1);
    check({name, " done latency"}, 32'(cyc + 1), 32'(2 + n_iter * T_ITER));
    check({name, " busy low at done"}, 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset converged", 32'(converged), 32'd0);
    check("reset iter_count", 32'(iter_count), 32'd0);
    check("reset point_action[0]", 32'(point_action[0]), 32'd0);
    check("reset alpha_out[0][0]", 32'(alpha_out[0][0]), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Zero iterations: initial vectors come straight back.
    set_trivial(16'd0);
    for (int p = 0; p < N_PT; p++)
      for (int s = 0; s < N_S; s++) alpha_in[p][s] = 16'd5;
    push_constant(16'd0, 1'b0, 16'd5);
    run("zero_iter", 0, -1);
    check_results("zero_iter");

    // Trivial model converges on the second iteration.
    set_trivial(16'd5);
    push_reward_model(16'd2, 1'b1);
    run("trivial", 2, -1);
    check_results("trivial");
    check("trivial p0 action", 32'(point_action[0]), 32'd0);
    check("trivial p0 alpha0", 32'(alpha_out[0][0]), 32'd7209);
    check("trivial p1 action", 32'(point_action[1]), 32'd2);
    check("trivial p1 alpha1", 32'(alpha_out[1][1]), 32'd6488);

    // Iteration limit hit before the eps test can pass.
    set_trivial(16'd1);
    push_reward_model(16'd1, 1'b0);
    run("iter_limit", 1, -1);
    check_results("iter_limit");

    // A second start 100 cycles in must change nothing.
    set_trivial(16'd1);
    push_reward_model(16'd1, 1'b0);
    run("busy_ignore", 1, 100);
    check_results("busy_ignore");

    // Reset mid-run clears outputs asynchronously and yields no done.
    set_trivial(16'd5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst converged", 32'(converged), 32'd0);
    check("midrst iter_count", 32'(iter_count), 32'd0);
    for (int p = 0; p < N_PT; p++) begin
      check($sformatf("midrst action[%0d]", p), 32'(point_action[p]), 32'd0);
      check($sformatf("midrst alpha[%0d][0]", p), 32'(alpha_out[p][0]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (300) begin @(negedge clk); if (done || busy) seen = 1'b1; end
      check("midrst no activity after", 32'(seen), 32'd0);
    end

    // Saturation: every sum clips to all-ones, no wrap; converges at once.
    for (int a = 0; a < N_A; a++)
      for (int s = 0; s < N_S; s++) begin
        vec_reward[a][s] = 16'hffff;
        for (int sp = 0; sp < N_S; sp++) trans[a][s][sp] = (s == sp) ? 16'hffff : 16'h0000;
        observe[a][s][0] = 16'hffff;
        observe[a][s][1] = 16'h0000;
      end
    for (int p = 0; p < N_PT; p++)
      for (int s = 0; s < N_S; s++) alpha_in[p][s] = 16'hffff;
    discount = 16'hffff; eps = '0; max_iter = 16'd3;
    set_beliefs();
    push_constant(16'd1, 1'b1, 16'hffff);
    run("saturate", 1, -1);
    check_results("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
